// File: rtl/sync_pattern_tx.sv
// J/K line-symbol transmitter: emits SYNC, one NRZI-encoded bit-stuffed data word, then EOP.
// Output symbols are registered so each one appears cleanly after the edge that selects it.
module sync_pattern_tx #(
    parameter int DATA_W       = 8,
    parameter int SYNC_LEN     = 8,
    parameter int CLKS_PER_SYM = 1,
    parameter int STUFF_RUN    = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              err_inject,
    output logic              out_k,
    output logic              out_j,
    output logic              out_en,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int TMR_W   = $clog2(CLKS_PER_SYM) + 1;
    localparam int IDX_MAX = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int IDX_W   = $clog2(IDX_MAX) + 1;
    localparam int ONES_W  = $clog2(STUFF_RUN) + 1;

    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(CLKS_PER_SYM - 1);
    localparam logic [IDX_W-1:0]  SYNC_LAST  = IDX_W'(SYNC_LEN - 1);
    localparam logic [IDX_W-1:0]  SYNC_PEN   = IDX_W'(SYNC_LEN - 2);
    localparam logic [IDX_W-1:0]  DATA_LAST  = IDX_W'(DATA_W - 1);
    localparam logic [ONES_W-1:0] ONES_LIMIT = ONES_W'(STUFF_RUN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_STUFF,
        S_EOP
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              k_q, k_d;
    logic              j_q, j_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              emit_bit;
    logic              enter_eop;
    logic [ONES_W-1:0] ones_base;
    logic              nk;

    // Sync symbol i is K when i is even or one of the last two; err corrupts the final one to J.
    function automatic logic sync_is_k(input logic [IDX_W-1:0] idx, input logic err);
        logic is_k;
        if (idx == SYNC_LAST) begin
            is_k = ~err;
        end else if (idx == SYNC_PEN) begin
            is_k = 1'b1;
        end else begin
            is_k = ~idx[0];
        end
        return is_k;
    endfunction

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        idx_d     = idx_q;
        ones_d    = ones_q;
        data_d    = data_q;
        err_d     = err_q;
        k_d       = k_q;
        j_d       = j_q;
        en_d      = en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        emit_bit  = 1'b0;
        enter_eop = 1'b0;
        ones_base = '0;
        nk        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    state_d = S_SYNC;
                    tmr_d   = '0;
                    idx_d   = '0;
                    data_d  = tx_data;
                    err_d   = err_inject;
                    k_d     = sync_is_k('0, err_inject);
                    j_d     = ~sync_is_k('0, err_inject);
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                if (tmr_q != TMR_LAST) begin
                    tmr_d = tmr_q + TMR_W'(1);
                end else begin
                    tmr_d = '0;
                    case (state_q)
                        S_SYNC: begin
                            if (idx_q != SYNC_LAST) begin
                                idx_d = idx_q + IDX_W'(1);
                                k_d   = sync_is_k(idx_q + IDX_W'(1), err_q);
                                j_d   = ~sync_is_k(idx_q + IDX_W'(1), err_q);
                            end else begin
                                state_d   = S_DATA;
                                idx_d     = '0;
                                emit_bit  = 1'b1;
                                ones_base = '0;
                            end
                        end
                        S_DATA: begin
                            // A full run of ones forces a toggle before anything else, even after the last bit.
                            if (ones_q == ONES_LIMIT) begin
                                state_d = S_STUFF;
                                ones_d  = '0;
                                k_d     = ~k_q;
                                j_d     = k_q;
                            end else if (idx_q != DATA_LAST) begin
                                idx_d     = idx_q + IDX_W'(1);
                                emit_bit  = 1'b1;
                                ones_base = ones_q;
                            end else begin
                                enter_eop = 1'b1;
                            end
                        end
                        S_STUFF: begin
                            if (idx_q != DATA_LAST) begin
                                state_d   = S_DATA;
                                idx_d     = idx_q + IDX_W'(1);
                                emit_bit  = 1'b1;
                                ones_base = ones_q;
                            end else begin
                                enter_eop = 1'b1;
                            end
                        end
                        S_EOP: begin
                            if (idx_q == IDX_W'(0)) begin
                                idx_d = IDX_W'(1);
                            end else if (idx_q == IDX_W'(1)) begin
                                idx_d = IDX_W'(2);
                                k_d   = 1'b0;
                                j_d   = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                                idx_d   = '0;
                                k_d     = 1'b0;
                                j_d     = 1'b1;
                                en_d    = 1'b0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end
        endcase

        // NRZI: a 0 toggles the line, a 1 repeats the previous J/K symbol.
        if (emit_bit) begin
            state_d = S_DATA;
            data_d  = data_q >> 1;
            if (data_q[0]) begin
                nk     = k_q;
                ones_d = ones_base + ONES_W'(1);
            end else begin
                nk     = ~k_q;
                ones_d = '0;
            end
            k_d = nk;
            j_d = ~nk;
        end

        if (enter_eop) begin
            state_d = S_EOP;
            idx_d   = '0;
            k_d     = 1'b0;
            j_d     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            ones_q  <= '0;
            k_q     <= 1'b0;
            j_q     <= 1'b1;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
            k_q     <= k_d;
            j_q     <= j_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
        data_q <= data_d;
        err_q  <= err_d;
    end

    assign out_k   = k_q;
    assign out_j   = j_q;
    assign out_en  = en_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_sync_pattern_tx.sv
// Directed bench for sync_pattern_tx: table of frames with hand-written symbol strings,
// plus sequences for ignored starts, mid-frame reset and slow-symbol back-to-back frames.
module tb_sync_pattern_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start1, err1, k1, j1, en1, busy1, done1;
    logic [7:0] data1;
    logic       start4, err4, k4, j4, en4, busy4, done4;
    logic [7:0] data4;

    sync_pattern_tx #(.DATA_W(8), .SYNC_LEN(8), .CLKS_PER_SYM(1), .STUFF_RUN(6)) u_dut1 (
        .CLK(clk), .RST(rst), .tx_start(start1), .tx_data(data1), .err_inject(err1),
        .out_k(k1), .out_j(j1), .out_en(en1), .tx_busy(busy1), .tx_done(done1)
    );

    sync_pattern_tx #(.DATA_W(8), .SYNC_LEN(8), .CLKS_PER_SYM(4), .STUFF_RUN(6)) u_dut4 (
        .CLK(clk), .RST(rst), .tx_start(start4), .tx_data(data4), .err_inject(err4),
        .out_k(k4), .out_j(j4), .out_en(en4), .tx_busy(busy4), .tx_done(done4)
    );

    // Observed vector layout: {en, k, j, busy, done}
    localparam logic [4:0] IDLE_V = 5'b00100;
    localparam logic [4:0] DONE_V = 5'b00101;

    typedef struct {
        logic [7:0] data;
        logic       err;
        string      syms;
    } vec_t;

    vec_t vecs[7];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {en,k,j,busy,done}=%b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [4:0] obs(input int which);
        return (which == 1) ? {en1, k1, j1, busy1, done1} : {en4, k4, j4, busy4, done4};
    endfunction

    function automatic logic [4:0] sym_exp(input byte c);
        logic [4:0] v;
        case (c)
            "K":     v = 5'b11010;
            "J":     v = 5'b10110;
            default: v = 5'b10010;
        endcase
        return v;
    endfunction

    task automatic set_in(input int which, input logic st, input logic [7:0] d, input logic e);
        if (which == 1) begin
            start1 = st; data1 = d; err1 = e;
        end else begin
            start4 = st; data4 = d; err4 = e;
        end
    endtask

    // Call at a negedge; returns right after the acceptance edge.
    task automatic start_frame(input int which, input logic [7:0] d, input logic e);
        set_in(which, 1'b1, d, e);
        @(posedge clk);
    endtask

    // Checks every cycle of the frame, then the tx_done cycle; returns at that cycle's negedge.
    task automatic check_frame(input int which, input string tag, input string syms,
                               input int clks, input int pulse_at);
        for (int i = 0; i < syms.len(); i++) begin
            for (int c = 0; c < clks; c++) begin
                @(negedge clk);
                if (i == pulse_at && c == 0) set_in(which, 1'b1, 8'hFF, 1'b1);
                else                         set_in(which, 1'b0, 8'h00, 1'b0);
                chk($sformatf("%s sym%0d cyc%0d", tag, i, c), obs(which), sym_exp(syms[i]));
            end
        end
        @(negedge clk);
        set_in(which, 1'b0, 8'h00, 1'b0);
        chk($sformatf("%s done", tag), obs(which), DONE_V);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h00, 1'b0, "KJKJKJKKJKJKJKJK00J"};
        vecs[1] = '{8'hFF, 1'b0, "KJKJKJKKKKKKKKJJJ00J"};
        vecs[2] = '{8'h00, 1'b1, "KJKJKJKJKJKJKJKJ00J"};
        vecs[3] = '{8'hA5, 1'b0, "KJKJKJKKKJJKJJKK00J"};
        vecs[4] = '{8'h3F, 1'b0, "KJKJKJKKKKKKKKJKJ00J"};
        vecs[5] = '{8'hFC, 1'b0, "KJKJKJKKJKKKKKKKJ00J"};
        vecs[6] = '{8'h7E, 1'b1, "KJKJKJKJKKKKKKKJK00J"};

        rst = 1'b0;
        set_in(1, 1'b1, 8'h55, 1'b0);
        set_in(4, 1'b1, 8'h55, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset dut1", obs(1), IDLE_V);
        chk("reset dut4", obs(4), IDLE_V);
        rst = 1'b1;
        set_in(1, 1'b0, 8'h00, 1'b0);
        set_in(4, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("post-reset idle dut1", obs(1), IDLE_V);
        chk("post-reset idle dut4", obs(4), IDLE_V);

        // Frames run back to back: each new start is raised in the previous tx_done cycle.
        for (int v = 0; v < 7; v++) begin
            start_frame(1, vecs[v].data, vecs[v].err);
            check_frame(1, $sformatf("vec%0d", v), vecs[v].syms, 1, -1);
        end
        @(negedge clk);
        chk("idle after table", obs(1), IDLE_V);

        // A start pulse during DATA must be neither honoured nor queued.
        start_frame(1, 8'h00, 1'b0);
        check_frame(1, "midstart", vecs[0].syms, 1, 10);
        @(negedge clk);
        chk("midstart not queued", obs(1), IDLE_V);

        // Reset during DATA aborts the frame without a tx_done pulse.
        start_frame(1, 8'h00, 1'b0);
        @(negedge clk);
        set_in(1, 1'b0, 8'h00, 1'b0);
        repeat (10) @(negedge clk);
        chk("abort pre-reset sym10", obs(1), sym_exp("J"));
        rst = 1'b0;
        @(negedge clk);
        chk("abort reset idle", obs(1), IDLE_V);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort no done %0d", i), obs(1), IDLE_V);
        end

        // Four clocks per symbol: 19-symbol frame is 76 cycles, next start lands in the tx_done cycle.
        start_frame(4, 8'hA5, 1'b0);
        check_frame(4, "slowA5", vecs[3].syms, 4, -1);
        start_frame(4, 8'hFF, 1'b0);
        check_frame(4, "slowFF", vecs[1].syms, 4, -1);
        @(negedge clk);
        chk("slow idle", obs(4), IDLE_V);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
